// File: rtl/post_mac_pkg.sv
// Shared types and helpers for the post-MAC pipeline.
// Mode encoding and the shift-then-clamp primitive.
package post_mac_pkg;

  typedef enum logic [1:0] {
    CONV_CH  = 2'b00,
    CONV_SUM = 2'b01,
    FC       = 2'b10,
    FC_ACC   = 2'b11
  } mac_mode_e;

  // Arithmetic shift then clamp to a signed out_w range.
  function automatic logic signed [63:0] sat_shift(
    input logic signed [63:0] v,
    input int                 shift,
    input int                 out_w
  );
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = v >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (sh > hi) return hi;
    if (sh < lo) return lo;
    return sh;
  endfunction

endpackage

// File: rtl/post_mac_lane.sv
// One lane of the output stage: optional ReLU, shift, clamp.
// Raises sat when the clamp changed the shifted value.
module post_mac_lane
  import post_mac_pkg::*;
#(
  parameter int IN_W       = 41,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 3
) (
  input  logic signed [IN_W-1:0]  in_val,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] out_val,
  output logic                    sat
);

  logic signed [63:0] ext;
  logic signed [63:0] shifted;
  logic signed [63:0] clamped;

  always_comb begin
    ext = 64'(in_val);
    if (relu_en && in_val < 0) ext = '0;
    shifted = ext >>> FRAC_SHIFT;
    clamped = sat_shift(ext, FRAC_SHIFT, OUT_W);
    out_val = clamped[OUT_W-1:0];
    sat     = (clamped != shifted);
  end

endmodule

// File: rtl/post_mac_pipe.sv
// Two-stage post-accumulation pipeline: bias/sum/FC partials in S1,
// shift/ReLU/saturate in S2, valid/ready with a global stall.
module post_mac_pipe
  import post_mac_pkg::*;
#(
  parameter int NUM_CH     = 6,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 3,
  parameter int SAT_CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_mode,
  input  logic                    in_last,
  input  logic [NUM_CH*ACC_W-1:0] in_acc,
  input  logic [NUM_CH*ACC_W-1:0] in_bias,
  input  logic [ACC_W-1:0]        in_sum_bias,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*OUT_W-1:0] out_data,
  output logic [OUT_W-1:0]        out_sum,
  output logic [1:0]              out_mode,
  output logic [SAT_CNT_W-1:0]    sat_cnt,
  input  logic                    sat_clr
);

  localparam int SUM_W  = ACC_W + $clog2(NUM_CH + 1);
  localparam int P_W    = ACC_W + 8;
  localparam int L_W    = P_W + 1;
  localparam int CNT_IW = $clog2(NUM_CH + 2);

  logic en;
  logic fire;
  mac_mode_e mode;

  logic                    s1_valid_q, s1_valid_d;
  mac_mode_e               s1_mode_q, s1_mode_d;
  logic signed [SUM_W-1:0] s1_sum_q, s1_sum_d;
  logic signed [L_W-1:0]   s1_lane_q [NUM_CH];
  logic signed [L_W-1:0]   s1_lane_d [NUM_CH];
  logic signed [P_W-1:0]   part_q [NUM_CH];
  logic signed [P_W-1:0]   part_d [NUM_CH];

  logic signed [ACC_W-1:0] acc_l;
  logic signed [ACC_W-1:0] bias_l;
  logic signed [SUM_W-1:0] sum_acc;

  logic                    out_valid_q, out_valid_d;
  logic [NUM_CH*OUT_W-1:0] out_data_q, out_data_d;
  logic [OUT_W-1:0]        out_sum_q, out_sum_d;
  mac_mode_e               out_mode_q, out_mode_d;
  logic [SAT_CNT_W-1:0]    sat_cnt_q, sat_cnt_d;

  logic signed [OUT_W-1:0] lane_out [NUM_CH];
  logic [NUM_CH-1:0]       lane_sat;
  logic signed [OUT_W-1:0] sum_out;
  logic                    sum_sat;
  logic [CNT_IW-1:0]       inc;
  logic [SAT_CNT_W:0]      cnt_sum;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign fire      = in_valid && en;
  assign mode      = mac_mode_e'(in_mode);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sum   = out_sum_q;
  assign out_mode  = out_mode_q;
  assign sat_cnt   = sat_cnt_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_sum_d   = s1_sum_q;
    s1_lane_d  = s1_lane_q;
    part_d     = part_q;
    acc_l      = '0;
    bias_l     = '0;
    sum_acc    = SUM_W'($signed(in_sum_bias));
    if (en) begin
      s1_valid_d = 1'b0;
      if (fire) begin
        s1_mode_d  = mode;
        s1_valid_d = !(mode == FC_ACC && !in_last);
        s1_sum_d   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
          acc_l        = in_acc[i*ACC_W +: ACC_W];
          bias_l       = in_bias[i*ACC_W +: ACC_W];
          s1_lane_d[i] = '0;
          unique case (mode)
            CONV_CH:  s1_lane_d[i] = L_W'(acc_l) + L_W'(bias_l);
            CONV_SUM: sum_acc = sum_acc + SUM_W'(acc_l);
            FC:       s1_lane_d[i] = L_W'(acc_l);
            FC_ACC: begin
              if (in_last) begin
                s1_lane_d[i] = L_W'(part_q[i]) + L_W'(acc_l);
                part_d[i]    = '0;
              end else begin
                part_d[i] = part_q[i] + P_W'(acc_l);
              end
            end
            default: ;
          endcase
        end
        if (mode == CONV_SUM) s1_sum_d = sum_acc;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    post_mac_lane #(
      .IN_W(L_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)
    ) u_lane (
      .in_val (s1_lane_q[g]),
      .relu_en(s1_mode_q == CONV_CH),
      .out_val(lane_out[g]),
      .sat    (lane_sat[g])
    );
  end

  post_mac_lane #(
    .IN_W(SUM_W), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)
  ) u_sum (
    .in_val (s1_sum_q),
    .relu_en(1'b1),
    .out_val(sum_out),
    .sat    (sum_sat)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sum_d   = out_sum_q;
    out_mode_d  = out_mode_q;
    inc         = CNT_IW'(sum_sat);
    for (int i = 0; i < NUM_CH; i++) begin
      inc = inc + CNT_IW'(lane_sat[i]);
    end
    if (!(en && s1_valid_q)) inc = '0;
    if (en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        for (int i = 0; i < NUM_CH; i++) begin
          out_data_d[i*OUT_W +: OUT_W] = lane_out[i];
        end
        out_sum_d  = sum_out;
        out_mode_d = s1_mode_q;
      end
    end
    // Clamp the counter at all-ones; a clear beats a same-cycle increment.
    cnt_sum = {1'b0, sat_cnt_q} + (SAT_CNT_W+1)'(inc);
    if (sat_clr)               sat_cnt_d = '0;
    else if (cnt_sum[SAT_CNT_W]) sat_cnt_d = '1;
    else                       sat_cnt_d = cnt_sum[SAT_CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= CONV_CH;
      s1_sum_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        s1_lane_q[i] <= '0;
        part_q[i]    <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sum_q   <= '0;
      out_mode_q  <= CONV_CH;
      sat_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_sum_q    <= s1_sum_d;
      s1_lane_q   <= s1_lane_d;
      part_q      <= part_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sum_q   <= out_sum_d;
      out_mode_q  <= out_mode_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

endmodule

// File: tb/tb_post_mac_pipe.sv
// Directed bench for post_mac_pipe with hand-computed expectations.
module tb_post_mac_pipe;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_mode;
  logic         in_last;
  logic [191:0] in_acc;
  logic [191:0] in_bias;
  logic [31:0]  in_sum_bias;
  logic         out_valid;
  logic         out_ready;
  logic [95:0]  out_data;
  logic [15:0]  out_sum;
  logic [1:0]   out_mode;
  logic [15:0]  sat_cnt;
  logic         sat_clr;

  logic signed [31:0] acc_v  [6];
  logic signed [31:0] bias_v [6];

  int total = 0;
  int pass  = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      in_acc[i*32 +: 32]  = acc_v[i];
      in_bias[i*32 +: 32] = bias_v[i];
    end
  end

  post_mac_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_last(in_last),
    .in_acc(in_acc), .in_bias(in_bias),
    .in_sum_bias(in_sum_bias),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sum(out_sum),
    .out_mode(out_mode), .sat_cnt(sat_cnt),
    .sat_clr(sat_clr)
  );

  function automatic logic signed [15:0] lane(input int i);
    return out_data[i*16 +: 16];
  endfunction

  task automatic zero_vecs();
    for (int i = 0; i < 6; i++) begin
      acc_v[i]  = '0;
      bias_v[i] = '0;
    end
    in_sum_bias = '0;
  endtask

  // Drive one beat for one cycle; returns at the negedge with it in S1.
  task automatic send(input logic [1:0] m, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_mode  = m;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 2'b00; in_last = 1'b0;
    out_ready = 1'b1; sat_clr = 1'b0;
    zero_vecs();
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b want 0", out_valid);
    else pass++;
    total++;
    if (out_data !== 96'd0 || out_sum !== 16'd0)
      $display("FAIL rst_out_data got %h/%h want 0", out_data, out_sum);
    else pass++;
    total++;
    if (sat_cnt !== 16'd0) $display("FAIL rst_sat_cnt got %0d want 0", sat_cnt);
    else pass++;
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %0b want 1", in_ready);
    else pass++;
  endtask

  task automatic test_conv_ch();
    zero_vecs();
    acc_v[0] = 80;   bias_v[0] = 8;
    acc_v[1] = -100; bias_v[1] = 4;
    send(2'b00, 1'b0);
    total++;
    if (out_valid !== 1'b0) $display("FAIL conv_lat1 got %0b want 0", out_valid);
    else pass++;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1) $display("FAIL conv_lat2 got %0b want 1", out_valid);
    else pass++;
    total++;
    if (lane(0) !== 16'sd11) $display("FAIL conv_lane0 got %0d want 11", lane(0));
    else pass++;
    total++;
    if (lane(1) !== 16'sd0) $display("FAIL conv_lane1_relu got %0d want 0", lane(1));
    else pass++;
    total++;
    if (out_sum !== 16'd0 || out_mode !== 2'b00)
      $display("FAIL conv_sum_mode got %0d/%0d want 0/0", out_sum, out_mode);
    else pass++;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL conv_single got %0b want 0", out_valid);
    else pass++;
  endtask

  task automatic test_conv_sum();
    zero_vecs();
    for (int i = 0; i < 6; i++) acc_v[i] = 16;
    in_sum_bias = 8;
    send(2'b01, 1'b0);
    @(negedge clk);
    total++;
    if (out_sum !== 16'd13) $display("FAIL sum_pos got %0d want 13", out_sum);
    else pass++;
    total++;
    if (out_data !== 96'd0) $display("FAIL sum_data got %h want 0", out_data);
    else pass++;
    zero_vecs();
    acc_v[0] = -50;
    send(2'b01, 1'b0);
    @(negedge clk);
    total++;
    if (out_sum !== 16'd0 || out_mode !== 2'b01)
      $display("FAIL sum_neg got %0d/%0d want 0/1", out_sum, out_mode);
    else pass++;
  endtask

  task automatic test_sat();
    zero_vecs();
    acc_v[0] = 32'sh0010_0000;
    acc_v[1] = -32'sh0010_0000;
    total++;
    if (sat_cnt !== 16'd0) $display("FAIL sat_pre got %0d want 0", sat_cnt);
    else pass++;
    send(2'b10, 1'b0);
    @(negedge clk);
    total++;
    if (lane(0) !== 16'sd32767) $display("FAIL sat_hi got %0d want 32767", lane(0));
    else pass++;
    total++;
    if (lane(1) !== -16'sd32768) $display("FAIL sat_lo got %0d want -32768", lane(1));
    else pass++;
    total++;
    if (sat_cnt !== 16'd2) $display("FAIL sat_cnt2 got %0d want 2", sat_cnt);
    else pass++;
    send(2'b10, 1'b0);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    total++;
    if (sat_cnt !== 16'd0) $display("FAIL sat_clr_wins got %0d want 0", sat_cnt);
    else pass++;
    total++;
    if (out_valid !== 1'b1 || lane(0) !== 16'sd32767)
      $display("FAIL sat_clr_out got %0b/%0d want 1/32767", out_valid, lane(0));
    else pass++;
  endtask

  task automatic test_fc_acc();
    int n_out;
    logic signed [15:0] v0, v1;
    logic [1:0] m;
    n_out = 0; v0 = '0; v1 = '0; m = '0;
    zero_vecs();
    acc_v[0] = 40;
    acc_v[1] = -16;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) begin
        n_out++;
        v0 = lane(0); v1 = lane(1); m = out_mode;
      end
      in_valid = (c < 3);
      in_mode  = 2'b11;
      in_last  = (c == 2);
    end
    in_valid = 1'b0; in_last = 1'b0;
    total++;
    if (n_out !== 1) $display("FAIL fcacc_count got %0d want 1", n_out);
    else pass++;
    total++;
    if (v0 !== 16'sd15 || v1 !== -16'sd6)
      $display("FAIL fcacc_val got %0d/%0d want 15/-6", v0, v1);
    else pass++;
    total++;
    if (m !== 2'b11) $display("FAIL fcacc_mode got %0d want 3", m);
    else pass++;
    acc_v[1] = 0;
    send(2'b11, 1'b1);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || lane(0) !== 16'sd5)
      $display("FAIL fcacc_cleared got %0b/%0d want 1/5", out_valid, lane(0));
    else pass++;
  endtask

  task automatic test_back_to_back();
    int idx, exp_v, got;
    logic stalled_prev;
    logic [95:0] held;
    idx = 0; exp_v = 1; got = 0; stalled_prev = 1'b0; held = '0;
    zero_vecs();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 7);
      in_mode   = 2'b00;
      in_valid  = (idx < 10);
      acc_v[0]  = 8 * (idx + 1);
      #1;
      if (out_valid && !out_ready) begin
        total++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready c=%0d got %0b want 0", c, in_ready);
        else pass++;
        if (stalled_prev) begin
          total++;
          if (out_data !== held) $display("FAIL bp_hold c=%0d got %h want %h", c, out_data, held);
          else pass++;
        end
        held = out_data;
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        total++;
        if (lane(0) !== 16'(exp_v)) $display("FAIL bp_order got %0d want %0d", lane(0), exp_v);
        else pass++;
        exp_v++;
        got++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (got !== 10 || idx !== 10) $display("FAIL bp_count got %0d/%0d want 10/10", got, idx);
    else pass++;
  endtask

  task automatic test_reset_mid_group();
    zero_vecs();
    acc_v[0] = 40;
    send(2'b11, 1'b0);
    send(2'b11, 1'b0);
    acc_v[0] = 32'sh0010_0000;
    send(2'b10, 1'b0);
    @(negedge clk);
    total++;
    if (sat_cnt !== 16'd1) $display("FAIL rmg_sat_pre got %0d want 1", sat_cnt);
    else pass++;
    send(2'b10, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || sat_cnt !== 16'd0)
      $display("FAIL rmg_in_reset got %0b/%0d want 0/0", out_valid, sat_cnt);
    else pass++;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL rmg_dropped got %0b want 0", out_valid);
    else pass++;
    acc_v[0] = 40;
    send(2'b11, 1'b1);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || lane(0) !== 16'sd5)
      $display("FAIL rmg_out got %0b/%0d want 1/5", out_valid, lane(0));
    else pass++;
    total++;
    if (sat_cnt !== 16'd0) $display("FAIL rmg_sat got %0d want 0", sat_cnt);
    else pass++;
  endtask

  initial begin
    test_reset();
    test_conv_ch();
    test_conv_sum();
    test_sat();
    test_fc_acc();
    test_back_to_back();
    test_reset_mid_group();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/post_mac_pipe.md
# post_mac_pipe

Pipelined, parametrised post-accumulation stage between the MAC array and the activation buffers. It applies per-channel bias, cross-channel summation, an arithmetic fixed-point shift, optional ReLU and signed saturation to `NUM_CH` accumulator lanes. It adds a valid/ready handshake and a multi-beat fully-connected accumulation mode. It replaces the purely combinational post-MAC logic, which truncated results and had no flow control.

## Interface
- `NUM_CH`, default 6: number of MAC lanes.
- `ACC_W`, default 32: accumulator and bias width, signed.
- `OUT_W`, default 16: output width, signed.
- `FRAC_SHIFT`, default 3: arithmetic right shift applied before saturation.
- `SAT_CNT_W`, default 16: width of the saturation event counter.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: input beat accepted when `in_valid && in_ready`.
- `in_mode` in 2: `CONV_CH`=00, `CONV_SUM`=01, `FC`=10, `FC_ACC`=11.
- `in_last` in 1: final beat of an `FC_ACC` group; ignored in other modes.
- `in_acc` in `NUM_CH*ACC_W`: lane `i` occupies bits `[i*ACC_W +: ACC_W]`.
- `in_bias` in `NUM_CH*ACC_W`: per-lane bias.
- `in_sum_bias` in `ACC_W`: bias for `CONV_SUM`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out `NUM_CH*OUT_W`: per-lane results.
- `out_sum` out `OUT_W`: `CONV_SUM` result.
- `out_mode` out 2: mode of the emitted beat.
- `sat_cnt` out `SAT_CNT_W`: number of saturation events. Saturates at all-ones.
- `sat_clr` in 1: synchronous clear of `sat_cnt`.

## Operation
All arithmetic is signed. Stage-1 sums are `ACC_W + $clog2(NUM_CH+1)` bits wide so they cannot overflow.

Per-mode results (the shift is arithmetic by `FRAC_SHIFT`; "sat" clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1]):
- `CONV_CH`: `out_data[i] = sat(relu(acc[i] + bias[i]) >>> FRAC_SHIFT)`. `out_sum` = 0.
- `CONV_SUM`: `out_sum = sat(relu(Σacc[i] + sum_bias) >>> FRAC_SHIFT)`. `out_data` = 0.
- `FC`: `out_data[i] = sat(acc[i] >>> FRAC_SHIFT)`. No bias, no ReLU. `out_sum` = 0.
- `FC_ACC`:
  - On every accepted beat, per-lane partial registers add `acc[i]`.
  - Non-last beats produce no output.
  - On the `in_last` beat, the beat emits `sat((partial[i] + acc[i]) >>> FRAC_SHIFT)` as if it were `FC`, and the partials clear to 0 in the same cycle.
  - Partial width is `ACC_W + 8`. Overflow of the partial register wraps; groups are kept under 256 beats.
- Beats in any other mode leave pending `FC_ACC` partials untouched.

Saturation counting:
- Each lane or sum that clamps on an emitted beat increments `sat_cnt` by 1.
- Multiple clamps in one beat add their count.
- `sat_cnt` stops at its maximum value.
- When `sat_clr` and an increment occur in the same cycle, the clear wins.

## Timing
- Two-stage pipeline:
  - S1 registers the bias-added, summed or accumulated values.
  - S2 registers the shift, ReLU and saturated outputs.
- Latency is 2 cycles from input acceptance to `out_valid`.
- Global stall: `en = !out_valid || out_ready`, and `in_ready = en`, combinationally. When stalled, S1 and S2 both hold.
- Throughput is 1 beat per cycle with no bubbles while `out_ready` = 1.
- `out_*` is stable while `out_valid && !out_ready`.
- An `FC_ACC` non-last beat enters S1 as a bubble: it updates the partials, and no S1 valid is produced.
- Reset (`rst_n` low, asynchronous) clears:
  - `out_valid`, `out_data`, `out_sum`, `out_mode`, `sat_cnt` to 0;
  - all S1 registers and partials to 0.
- `in_ready` reads 1 once reset is released, because `out_valid` = 0.
- Reset in the middle of an `FC_ACC` group discards the group.
- A beat already in flight in S1 or S2 during reset is dropped.

## Structure
- Package `post_mac_pkg`: `mac_mode_e` enum (`CONV_CH`, `CONV_SUM`, `FC`, `FC_ACC`) and a `sat_shift` function, parametrised through its arguments.
- Sub-module `post_mac_lane`: a single lane's S2 shift/ReLU/saturate logic. It takes a relu enable and outputs a sat flag. Instantiate it `NUM_CH+1` times, one per lane plus one for the sum.
- Top: S1 registers, adder tree, `FC_ACC` partials, handshake, `sat_cnt`.

## Test plan
- `CONV_CH`:
  - lane 0 acc=80, bias=8 → `out_data[0]`=11;
  - lane 1 acc=-100, bias=4 → 0;
  - `out_valid` rises exactly 2 cycles after acceptance.
- `CONV_SUM`, all six acc=16, sum_bias=8 → `out_sum`=13 and `out_data` all 0. A sum of -50 → `out_sum`=0.
- Saturation:
  - `FC` lane acc=0x0010_0000 → 32767;
  - acc=-0x0010_0000 → -32768;
  - `sat_cnt` goes 0→2.
  - With `sat_clr` asserted on the same cycle as a clamp, `sat_cnt` = 0.
- `FC_ACC`: three beats, acc=40 each, `in_last` on the third → exactly one output of 15. Then one further beat of 40 with `in_last` → 5, confirming the partials cleared.
- Backpressure: stream 10 `CONV_CH` beats with `out_ready` low for cycles 3–7 → no loss or duplication, outputs held stable, and `in_ready` low during the stall.
- Reset mid-group: two `FC_ACC` non-last beats of 40, assert `rst_n` low, release, then send one last beat of 40 → output 5 and `sat_cnt` = 0.
